// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone slave bus between NUM_PORTS masters.
// A grant is held for the owner's whole cyc; a watchdog forces an ack if the slave goes silent.
module wb_rr_arbiter #(
  parameter int NUM_PORTS       = 2,
  parameter int ADDR_BITS       = 8,
  parameter int BYTES           = 1,
  parameter int SEL_WIDTH       = 1,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                           clk,
  input  logic                           areset,
  input  logic [NUM_PORTS*ADDR_BITS-1:0] s_wb_addr,
  input  logic [NUM_PORTS*BYTES*8-1:0]   s_wb_dat_m2s,
  output logic [NUM_PORTS*BYTES*8-1:0]   s_wb_dat_s2m,
  input  logic [NUM_PORTS-1:0]           s_wb_we,
  input  logic [NUM_PORTS-1:0]           s_wb_stb,
  input  logic [NUM_PORTS-1:0]           s_wb_cyc,
  input  logic [NUM_PORTS*SEL_WIDTH-1:0] s_wb_sel,
  output logic [NUM_PORTS-1:0]           s_wb_ack,
  output logic [NUM_PORTS-1:0]           s_wb_stall,
  output logic [ADDR_BITS-1:0]           m_wb_addr,
  output logic [BYTES*8-1:0]             m_wb_dat_m2s,
  input  logic [BYTES*8-1:0]             m_wb_dat_s2m,
  output logic                           m_wb_we,
  output logic                           m_wb_stb,
  output logic                           m_wb_cyc,
  output logic [SEL_WIDTH-1:0]           m_wb_sel,
  input  logic                           m_wb_ack,
  input  logic                           m_wb_stall,
  output logic [NUM_PORTS-1:0]           grant,
  output logic                           timeout_flag
);

  localparam int DW    = BYTES * 8;
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);

  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_PORTS - 1);

  typedef enum logic {
    ST_IDLE,
    ST_GRANTED
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q;
  logic [PTR_W-1:0]     owner_q;
  logic [PTR_W-1:0]     rr_ptr_q;
  logic [OUT_W-1:0]     outstanding_q;
  logic [TMR_W-1:0]     timer_q;
  logic                 timeout_flag_q;

  logic [ADDR_BITS-1:0] addr_arr [NUM_PORTS];
  logic [DW-1:0]        dat_arr  [NUM_PORTS];
  logic [SEL_WIDTH-1:0] sel_arr  [NUM_PORTS];

  logic             granted, owner_cyc, cap, accept;
  logic             ack_valid, forced_ack, route_ack, route_stall;
  logic [DW-1:0]    route_dat;
  logic             pick_found;
  logic [PTR_W-1:0] pick_idx, cand_idx;
  int               cand;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign addr_arr[p] = s_wb_addr[p*ADDR_BITS +: ADDR_BITS];
    assign dat_arr[p]  = s_wb_dat_m2s[p*DW +: DW];
    assign sel_arr[p]  = s_wb_sel[p*SEL_WIDTH +: SEL_WIDTH];

    // Only the owner sees responses; everyone else is held off.
    assign s_wb_ack[p]               = grant_q[p] & route_ack;
    assign s_wb_stall[p]             = ~grant_q[p] | route_stall;
    assign s_wb_dat_s2m[p*DW +: DW]  = grant_q[p] ? route_dat : '0;
  end

  assign granted   = (state_q == ST_GRANTED);
  assign owner_cyc = granted && s_wb_cyc[owner_q];
  assign cap       = (outstanding_q == OUT_MAX);

  // stb is also qualified by the owner's cyc so a release cycle can never be counted as a new strobe.
  assign m_wb_cyc     = owner_cyc;
  assign m_wb_stb     = owner_cyc && s_wb_stb[owner_q] && !cap;
  assign m_wb_addr    = granted ? addr_arr[owner_q] : '0;
  assign m_wb_dat_m2s = granted ? dat_arr[owner_q]  : '0;
  assign m_wb_sel     = granted ? sel_arr[owner_q]  : '0;
  assign m_wb_we      = granted && s_wb_we[owner_q];

  assign accept      = m_wb_stb && !m_wb_stall;
  assign ack_valid   = granted && m_wb_ack && (outstanding_q != '0);
  assign forced_ack  = WD_EN && granted && !m_wb_ack && (outstanding_q != '0) && (timer_q == TMR_LAST);
  assign route_ack   = ack_valid || forced_ack;
  assign route_stall = m_wb_stall || cap;
  assign route_dat   = forced_ack ? '0 : m_wb_dat_s2m;

  assign grant        = grant_q;
  assign timeout_flag = timeout_flag_q;

  // NOTE: every signal written in always_comb is given a default first so no latch is inferred.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand     = (int'(rr_ptr_q) + i) % NUM_PORTS;
      cand_idx = PTR_W'(cand);
      if (!pick_found && s_wb_cyc[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (pick_found) state_d = ST_GRANTED;
      ST_GRANTED: if (!owner_cyc) state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      grant_q        <= '0;
      owner_q        <= '0;
      rr_ptr_q       <= '0;
      outstanding_q  <= '0;
      timer_q        <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          outstanding_q <= '0;
          timer_q       <= '0;
          if (pick_found) begin
            owner_q <= pick_idx;
            grant_q <= NUM_PORTS'(1) << pick_idx;
          end
        end
        ST_GRANTED: begin
          if (!owner_cyc) begin
            // Release: responses still in flight are abandoned along with the count.
            grant_q       <= '0;
            outstanding_q <= '0;
            timer_q       <= '0;
            rr_ptr_q      <= (owner_q == PTR_LAST) ? '0 : owner_q + 1'b1;
          end else begin
            if (accept && !route_ack)      outstanding_q <= outstanding_q + 1'b1;
            else if (!accept && route_ack) outstanding_q <= outstanding_q - 1'b1;

            if (!WD_EN || m_wb_ack || route_ack || outstanding_q == '0) timer_q <= '0;
            else                                                        timer_q <= timer_q + 1'b1;

            if (forced_ack) timeout_flag_q <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed scenarios plus randomized request rounds
// compared against a round-robin model kept as a simple pointer and requester mask.
module tb_wb_rr_arbiter;

  localparam int N    = 2;
  localparam int AB   = 8;
  localparam int DW   = 8;
  localparam int MAXO = 4;
  localparam int TMO  = 16;

  logic            clk = 1'b0;
  logic            areset;
  logic [N*AB-1:0] s_wb_addr;
  logic [N*DW-1:0] s_wb_dat_m2s;
  logic [N*DW-1:0] s_wb_dat_s2m;
  logic [N-1:0]    s_wb_we, s_wb_stb, s_wb_cyc, s_wb_sel, s_wb_ack, s_wb_stall;
  logic [AB-1:0]   m_wb_addr;
  logic [DW-1:0]   m_wb_dat_m2s, m_wb_dat_s2m;
  logic            m_wb_we, m_wb_stb, m_wb_cyc, m_wb_ack, m_wb_stall;
  logic [0:0]      m_wb_sel;
  logic [N-1:0]    grant;
  logic            timeout_flag;

  int errors = 0;
  int checks = 0;
  int ptr_m  = 0;

  wb_rr_arbiter #(
    .NUM_PORTS(N), .ADDR_BITS(AB), .BYTES(1), .SEL_WIDTH(1),
    .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .areset(areset),
    .s_wb_addr(s_wb_addr), .s_wb_dat_m2s(s_wb_dat_m2s), .s_wb_dat_s2m(s_wb_dat_s2m),
    .s_wb_we(s_wb_we), .s_wb_stb(s_wb_stb), .s_wb_cyc(s_wb_cyc), .s_wb_sel(s_wb_sel),
    .s_wb_ack(s_wb_ack), .s_wb_stall(s_wb_stall),
    .m_wb_addr(m_wb_addr), .m_wb_dat_m2s(m_wb_dat_m2s), .m_wb_dat_s2m(m_wb_dat_s2m),
    .m_wb_we(m_wb_we), .m_wb_stb(m_wb_stb), .m_wb_cyc(m_wb_cyc), .m_wb_sel(m_wb_sel),
    .m_wb_ack(m_wb_ack), .m_wb_stall(m_wb_stall),
    .grant(grant), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after the rising edge; outputs are checked on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    s_wb_addr    = '0;
    s_wb_dat_m2s = '0;
    s_wb_we      = '0;
    s_wb_stb     = '0;
    s_wb_cyc     = '0;
    s_wb_sel     = '0;
    m_wb_dat_s2m = '0;
    m_wb_ack     = 1'b0;
    m_wb_stall   = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    areset = 1'b1;
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;
    ptr_m = 0;
  endtask

  // Reference arbitration: first requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [1:0] req, input int ptr);
    int cand;
    for (int i = 0; i < N; i++) begin
      cand = (ptr + i) % N;
      if (((req >> cand) & 2'b01) != 2'b00) return cand;
    end
    return -1;
  endfunction

  // One arbitration round starting in an idle cycle: request, nstb strobe/ack pairs, release.
  task automatic run_round(input logic [1:0] req, input int nstb, output logic [1:0] got_grant);
    int w;
    logic [1:0]  oh;
    logic [7:0]  exp_addr, exp_dat, rdat;
    logic        exp_we, exp_sel;
    logic [15:0] exp_rd;
    w  = model_pick(req, ptr_m);
    oh = 2'(1 << w);
    got_grant = '0;
    s_wb_cyc = req;
    s_wb_stb = '0;
    mid();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL round_idle_grant: got %b expected 00", grant); end
    checks++; if (s_wb_stall !== 2'b11) begin errors++; $display("FAIL round_idle_stall: got %b expected 11", s_wb_stall); end
    next_cycle();
    for (int k = 0; k < nstb; k++) begin
      s_wb_addr    = 16'($urandom);
      s_wb_dat_m2s = 16'($urandom);
      s_wb_we      = 2'($urandom);
      s_wb_sel     = 2'($urandom);
      s_wb_stb     = oh | (2'($urandom) & req & ~oh);
      m_wb_stall   = 1'b0;
      exp_addr = 8'(s_wb_addr >> (8 * w));
      exp_dat  = 8'(s_wb_dat_m2s >> (8 * w));
      exp_we   = 1'(s_wb_we >> w);
      exp_sel  = 1'(s_wb_sel >> w);
      mid();
      if (k == 0) got_grant = grant;
      checks++; if (grant !== oh) begin errors++; $display("FAIL round_grant: got %b expected %b", grant, oh); end
      checks++; if (m_wb_addr !== exp_addr || m_wb_dat_m2s !== exp_dat || m_wb_we !== exp_we || m_wb_sel !== exp_sel)
        begin errors++; $display("FAIL round_passthru: got %h/%h/%b/%b expected %h/%h/%b/%b",
          m_wb_addr, m_wb_dat_m2s, m_wb_we, m_wb_sel, exp_addr, exp_dat, exp_we, exp_sel); end
      checks++; if (m_wb_stb !== 1'b1 || m_wb_cyc !== 1'b1) begin errors++; $display("FAIL round_stb: got %b%b expected 11", m_wb_cyc, m_wb_stb); end
      checks++; if (s_wb_stall !== ~oh) begin errors++; $display("FAIL round_stall: got %b expected %b", s_wb_stall, ~oh); end
      next_cycle();
      s_wb_stb     = '0;
      rdat         = 8'($urandom);
      m_wb_ack     = 1'b1;
      m_wb_dat_s2m = rdat;
      exp_rd       = 16'({8'h00, rdat} << (8 * w));
      mid();
      checks++; if (s_wb_ack !== oh) begin errors++; $display("FAIL round_ack: got %b expected %b", s_wb_ack, oh); end
      checks++; if (s_wb_dat_s2m !== exp_rd) begin errors++; $display("FAIL round_rdata: got %h expected %h", s_wb_dat_s2m, exp_rd); end
      next_cycle();
      m_wb_ack = 1'b0;
    end
    s_wb_cyc = req & ~oh;
    mid();
    checks++; if (m_wb_cyc !== 1'b0 || grant !== oh) begin errors++; $display("FAIL round_release: got cyc=%b grant=%b expected cyc=0 grant=%b", m_wb_cyc, grant, oh); end
    next_cycle();
    ptr_m = (w + 1) % N;
  endtask

  task automatic test_reset();
    clear_inputs();
    areset   = 1'b1;
    s_wb_cyc = 2'b11;
    s_wb_stb = 2'b11;
    m_wb_ack = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
    checks++; if (m_wb_cyc !== 1'b0 || m_wb_stb !== 1'b0) begin errors++; $display("FAIL reset_cyc_stb: got %b%b expected 00", m_wb_cyc, m_wb_stb); end
    checks++; if (s_wb_ack !== 2'b00 || s_wb_stall !== 2'b11) begin errors++; $display("FAIL reset_ack_stall: got %b/%b expected 00/11", s_wb_ack, s_wb_stall); end
    checks++; if (s_wb_dat_s2m !== 16'h0000 || timeout_flag !== 1'b0) begin errors++; $display("FAIL reset_dat_flag: got %h/%b expected 0000/0", s_wb_dat_s2m, timeout_flag); end
    clear_inputs();
    @(posedge clk);
    #1 areset = 1'b0;
    ptr_m = 0;
  endtask

  task automatic test_single_port();
    s_wb_cyc     = 2'b01;
    s_wb_stb     = 2'b01;
    s_wb_we      = 2'b01;
    s_wb_sel     = 2'b01;
    s_wb_addr    = 16'h0005;
    s_wb_dat_m2s = 16'h00A5;
    m_wb_stall   = 1'b0;
    mid();
    checks++; if (grant !== 2'b00 || m_wb_cyc !== 1'b0) begin errors++; $display("FAIL single_latency: got grant=%b cyc=%b expected 00/0", grant, m_wb_cyc); end
    next_cycle();
    mid();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b expected 01", grant); end
    checks++; if (m_wb_addr !== 8'h05 || m_wb_dat_m2s !== 8'hA5 || m_wb_we !== 1'b1) begin errors++; $display("FAIL single_passthru: got %h/%h/%b expected 05/a5/1", m_wb_addr, m_wb_dat_m2s, m_wb_we); end
    checks++; if (m_wb_stb !== 1'b1 || s_wb_stall !== 2'b10) begin errors++; $display("FAIL single_stb: got stb=%b stall=%b expected 1/10", m_wb_stb, s_wb_stall); end
    next_cycle();
    s_wb_stb     = '0;
    m_wb_ack     = 1'b1;
    m_wb_dat_s2m = 8'h3C;
    mid();
    checks++; if (s_wb_ack !== 2'b01 || s_wb_dat_s2m !== 16'h003C) begin errors++; $display("FAIL single_ack: got %b/%h expected 01/003c", s_wb_ack, s_wb_dat_s2m); end
    next_cycle();
    m_wb_ack = 1'b0;
    s_wb_cyc = '0;
    mid();
    checks++; if (m_wb_cyc !== 1'b0 || grant !== 2'b01) begin errors++; $display("FAIL single_drop: got cyc=%b grant=%b expected 0/01", m_wb_cyc, grant); end
    next_cycle();
    mid();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_release: got %b expected 00", grant); end
    ptr_m = 1;
    next_cycle();
  endtask

  task automatic test_simultaneous();
    do_reset();
    s_wb_cyc = 2'b11;
    mid();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL simul_idle: got %b expected 00", grant); end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      mid();
      checks++; if (grant !== 2'b01 || s_wb_stall[1] !== 1'b1) begin errors++; $display("FAIL simul_port0: got grant=%b stall1=%b expected 01/1", grant, s_wb_stall[1]); end
    end
    next_cycle();
    s_wb_cyc = 2'b10;
    mid();
    checks++; if (grant !== 2'b01 || s_wb_stall[1] !== 1'b1 || m_wb_cyc !== 1'b0) begin errors++; $display("FAIL simul_drop: got grant=%b stall1=%b cyc=%b expected 01/1/0", grant, s_wb_stall[1], m_wb_cyc); end
    next_cycle();
    mid();
    checks++; if (grant !== 2'b00 || s_wb_stall !== 2'b11) begin errors++; $display("FAIL simul_dead: got grant=%b stall=%b expected 00/11", grant, s_wb_stall); end
    next_cycle();
    mid();
    checks++; if (grant !== 2'b10 || m_wb_cyc !== 1'b1) begin errors++; $display("FAIL simul_port1: got grant=%b cyc=%b expected 10/1", grant, m_wb_cyc); end
    next_cycle();
    s_wb_cyc = '0;
    mid();
    next_cycle();
    ptr_m = 0;
  endtask

  task automatic test_fairness();
    logic [1:0] exp_seq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0] g;
    for (int r = 0; r < 4; r++) begin
      run_round(2'b11, 1, g);
      checks++; if (g !== exp_seq[r]) begin errors++; $display("FAIL fair_round%0d: got %b expected %b", r, g, exp_seq[r]); end
    end
    clear_inputs();
  endtask

  task automatic test_random();
    logic [1:0] req, oh, g;
    req = 2'($urandom_range(1, 3));
    for (int r = 0; r < 24; r++) begin
      oh = 2'(1 << model_pick(req, ptr_m));
      run_round(req, int'($urandom_range(1, 3)), g);
      req = (req & ~oh & 2'($urandom)) | 2'($urandom);
      if (req == 2'b00) req = 2'(1 << $urandom_range(0, 1));
    end
    clear_inputs();
    mid();
    next_cycle();
  endtask

  task automatic test_max_outstanding();
    int out_m, sent, dut_acc;
    logic stb_want, cap_m, acc, ackv;
    do_reset();
    out_m = 0; sent = 0; dut_acc = 0;
    s_wb_cyc = 2'b01;
    mid();
    next_cycle();
    for (int c = 0; c < 14; c++) begin
      stb_want   = (sent < 6);
      s_wb_stb   = {1'b0, stb_want};
      s_wb_addr  = 16'($urandom);
      m_wb_stall = 1'b0;
      m_wb_ack   = (c >= 6);
      cap_m = (out_m == MAXO);
      acc   = stb_want && !cap_m;
      ackv  = m_wb_ack && (out_m > 0);
      mid();
      if (m_wb_stb && !m_wb_stall) dut_acc++;
      checks++; if (s_wb_stall[0] !== cap_m || m_wb_stb !== acc) begin errors++; $display("FAIL maxout_c%0d: got stall=%b stb=%b expected %b/%b", c, s_wb_stall[0], m_wb_stb, cap_m, acc); end
      checks++; if (s_wb_ack[0] !== ackv) begin errors++; $display("FAIL maxout_ack_c%0d: got %b expected %b", c, s_wb_ack[0], ackv); end
      if (c == 5) begin
        checks++; if (dut_acc !== 4) begin errors++; $display("FAIL maxout_cap: got %0d accepted expected 4", dut_acc); end
      end
      out_m = out_m + int'(acc) - int'(ackv);
      sent  = sent + int'(acc);
      next_cycle();
    end
    checks++; if (dut_acc !== 6) begin errors++; $display("FAIL maxout_total: got %0d accepted expected 6", dut_acc); end
    clear_inputs();
    mid();
    checks++; if (m_wb_cyc !== 1'b0 || timeout_flag !== 1'b0) begin errors++; $display("FAIL maxout_end: got cyc=%b flag=%b expected 0/0", m_wb_cyc, timeout_flag); end
    next_cycle();
    ptr_m = 1;
  endtask

  task automatic test_timeout();
    int forced_at;
    s_wb_cyc = 2'b01;
    mid();
    next_cycle();
    s_wb_stb   = 2'b01;
    m_wb_stall = 1'b0;
    mid();
    checks++; if (m_wb_stb !== 1'b1) begin errors++; $display("FAIL tmo_stb: got %b expected 1", m_wb_stb); end
    next_cycle();
    s_wb_stb     = '0;
    m_wb_ack     = 1'b0;
    m_wb_dat_s2m = 8'hFF;
    forced_at    = -1;
    for (int k = 1; k <= 20; k++) begin
      mid();
      if (s_wb_ack[0] === 1'b1 && forced_at < 0) forced_at = k;
      checks++; if (s_wb_ack !== ((k == TMO) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL tmo_ack_k%0d: got %b expected %b", k, s_wb_ack, (k == TMO) ? 2'b01 : 2'b00); end
      if (k == TMO) begin
        checks++; if (s_wb_dat_s2m !== 16'h0000 || timeout_flag !== 1'b0) begin errors++; $display("FAIL tmo_forced: got dat=%h flag=%b expected 0000/0", s_wb_dat_s2m, timeout_flag); end
      end
      if (k == TMO + 1) begin
        checks++; if (timeout_flag !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %b expected 1", timeout_flag); end
      end
      next_cycle();
    end
    checks++; if (forced_at !== TMO) begin errors++; $display("FAIL tmo_cycle: got %0d expected %0d", forced_at, TMO); end
    clear_inputs();
    mid();
    next_cycle();
    ptr_m = 1;
  endtask

  task automatic test_flag_sticky();
    logic [1:0] g;
    run_round(2'b11, 2, g);
    run_round(2'b01, 1, g);
    clear_inputs();
    mid();
    checks++; if (timeout_flag !== 1'b1) begin errors++; $display("FAIL flag_sticky: got %b expected 1", timeout_flag); end
    next_cycle();
  endtask

  task automatic test_areset_mid();
    s_wb_cyc   = 2'b01;
    m_wb_stall = 1'b0;
    mid();
    next_cycle();
    s_wb_stb = 2'b01;
    mid();
    next_cycle();
    mid();
    next_cycle();
    s_wb_stb = '0;
    checks++; if (grant !== 2'b01 || m_wb_cyc !== 1'b1) begin errors++; $display("FAIL arst_pre: got grant=%b cyc=%b expected 01/1", grant, m_wb_cyc); end
    #2;
    areset       = 1'b1;
    m_wb_ack     = 1'b1;
    m_wb_dat_s2m = 8'h5A;
    #1;
    checks++; if (m_wb_cyc !== 1'b0 || s_wb_stall !== 2'b11 || grant !== 2'b00) begin errors++; $display("FAIL arst_immediate: got cyc=%b stall=%b grant=%b expected 0/11/00", m_wb_cyc, s_wb_stall, grant); end
    checks++; if (s_wb_ack !== 2'b00 || s_wb_dat_s2m !== 16'h0000 || timeout_flag !== 1'b0) begin errors++; $display("FAIL arst_resp: got ack=%b dat=%h flag=%b expected 00/0000/0", s_wb_ack, s_wb_dat_s2m, timeout_flag); end
    @(posedge clk);
    #1;
    areset   = 1'b0;
    m_wb_ack = 1'b0;
    s_wb_cyc = 2'b10;
    ptr_m    = 0;
    mid();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL arst_idle: got %b expected 00", grant); end
    next_cycle();
    s_wb_stb = 2'b10;
    for (int k = 0; k < 5; k++) begin
      mid();
      checks++; if (grant !== 2'b10 || s_wb_stall[1] !== (k >= MAXO)) begin errors++; $display("FAIL arst_post_k%0d: got grant=%b stall1=%b expected 10/%b", k, grant, s_wb_stall[1], k >= MAXO); end
      next_cycle();
    end
    clear_inputs();
    mid();
    next_cycle();
    ptr_m = 0;
  endtask

  initial begin
    test_reset();
    test_single_port();
    test_simultaneous();
    test_fairness();
    test_random();
    test_max_outstanding();
    test_timeout();
    test_flag_sticky();
    test_areset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
